// File: rtl/shift_arb_pkg.sv
// rtl/shift_arb_pkg.sv - shared types and constants for shift_req_arbiter
// Contents:
//   state_t : FSM state (IDLE waiting for a request, RESP holding a result)
//   PORTS   : number of requester ports served by the arbiter
package shift_arb_pkg;

  typedef enum logic {IDLE, RESP} state_t;

  localparam int PORTS = 2;

endpackage

// File: rtl/multi_barrel_shifter_mux.sv
// rtl/multi_barrel_shifter_mux.sv - combinational bidirectional rotate
// Parameters:
//   N   : data width, power of 2, >= 2
// Ports:
//   a   in  N          operand
//   amt in  $clog2(N)  rotate amount (0 passes a through)
//   lr  in  1          direction, 1 = left, 0 = right
//   y   out N          rotated operand
module multi_barrel_shifter_mux #(
  parameter int N = 8
) (
  input  logic [N-1:0]         a,
  input  logic [$clog2(N)-1:0] amt,
  input  logic                 lr,
  output logic [N-1:0]         y
);

  localparam int AW = $clog2(N);
  localparam logic [AW:0] NW = (AW+1)'(N);

  // Complementary shift distance; equals N when amt is 0, which shifts
  // every bit out and leaves the pass-through term alone.
  logic [AW:0] inv;

  always_comb begin
    inv = NW - {1'b0, amt};
    if (lr) begin
      y = (a << amt) | (a >> inv);
    end else begin
      y = (a >> amt) | (a << inv);
    end
  end

endmodule

// File: rtl/shift_req_arbiter.sv
// rtl/shift_req_arbiter.sv - two-port arbiter/sequencer for one barrel shifter
// Configuration macro: SHIFT_ARB_RR_EN (defined = round-robin on contention,
//   undefined = fixed priority with port 0 winning contention)
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqX_valid/ready           request handshake per port (X = 0, 1)
//   reqX_a/amt/lr              operand, rotate amount, direction (1 = left)
//   respX_valid/ready          result handshake per port
//   resp_y                     registered result shared by both ports
//   grant_id                   owner of the in-flight or most recent operation
//   busy                       high whenever the FSM is not in IDLE
module shift_req_arbiter
  import shift_arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [N-1:0]         req0_a,
  input  logic [$clog2(N)-1:0] req0_amt,
  input  logic                 req0_lr,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [N-1:0]         req1_a,
  input  logic [$clog2(N)-1:0] req1_amt,
  input  logic                 req1_lr,
  output logic                 resp0_valid,
  input  logic                 resp0_ready,
  output logic                 resp1_valid,
  input  logic                 resp1_ready,
  output logic [N-1:0]         resp_y,
  output logic                 grant_id,
  output logic                 busy
);

  localparam int AW = $clog2(N);

  state_t         state;
  state_t         state_next;
  logic           winner;
  logic           accept;
  logic           owner_ready;
  logic [N-1:0]   sh_a;
  logic [AW-1:0]  sh_amt;
  logic           sh_lr;
  logic [N-1:0]   sh_y;

`ifdef SHIFT_ARB_RR_EN
  // Reset to 1 so port 0 wins the first contention.
  logic last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= winner;
    end
  end
`endif

  // Winner selection: a lone requester always wins; on contention the
  // configured policy decides.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef SHIFT_ARB_RR_EN
      winner = ~last_grant;
`else
      winner = 1'b0;
`endif
    end else if (req1_valid) begin
      winner = 1'b1;
    end
  end

  assign accept = (state == IDLE) && (req0_valid || req1_valid);

  assign req0_ready = (state == IDLE) && req0_valid && (winner == 1'b0);
  assign req1_ready = (state == IDLE) && req1_valid && (winner == 1'b1);

  // Shifter is driven by the winner; its output only matters on accept.
  always_comb begin
    if (winner) begin
      sh_a   = req1_a;
      sh_amt = req1_amt;
      sh_lr  = req1_lr;
    end else begin
      sh_a   = req0_a;
      sh_amt = req0_amt;
      sh_lr  = req0_lr;
    end
  end

  multi_barrel_shifter_mux #(.N(N)) u_shifter (
    .a   (sh_a),
    .amt (sh_amt),
    .lr  (sh_lr),
    .y   (sh_y)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Only the owner's resp_ready can release the response.
  assign owner_ready = grant_id ? resp1_ready : resp0_ready;

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RESP;
      RESP: if (owner_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result and owner are captured on accept and held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_y   <= '0;
      grant_id <= 1'b0;
    end else if (accept) begin
      resp_y   <= sh_y;
      grant_id <= winner;
    end
  end

  // Output logic
  always_comb begin
    resp0_valid = (state == RESP) && (grant_id == 1'b0);
    resp1_valid = (state == RESP) && (grant_id == 1'b1);
    busy        = (state != IDLE);
  end

endmodule

// File: tb/tb_shift_req_arbiter.sv
// tb/tb_shift_req_arbiter.sv - directed self-checking bench for shift_req_arbiter
module tb_shift_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_lr;
  logic [7:0] req0_a;
  logic [2:0] req0_amt;
  logic       req1_valid, req1_ready, req1_lr;
  logic [7:0] req1_a;
  logic [2:0] req1_amt;
  logic       resp0_valid, resp0_ready;
  logic       resp1_valid, resp1_ready;
  logic [7:0] resp_y;
  logic       grant_id;
  logic       busy;

  int checks;
  int errors;

  shift_req_arbiter #(.N(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_amt    (req0_amt),
    .req0_lr     (req0_lr),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_amt    (req1_amt),
    .req1_lr     (req1_lr),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp_y      (resp_y),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check1({tag, "_busy"},   busy, 1'b0);
    check1({tag, "_rv0"},    resp0_valid, 1'b0);
    check1({tag, "_rv1"},    resp1_valid, 1'b0);
    check8({tag, "_y"},      resp_y, 8'h00);
    check1({tag, "_grant"},  grant_id, 1'b0);
    check1({tag, "_rdy0"},   req0_ready, 1'b0);
    check1({tag, "_rdy1"},   req1_ready, 1'b0);
  endtask

  logic       exp_w;
  logic [7:0] exp_y;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = 8'h00; req0_amt = 3'd0; req0_lr = 1'b0;
    req1_valid = 1'b0; req1_a = 8'h00; req1_amt = 3'd0; req1_lr = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;

    // 1. reset state
    tick; tick;
    rst_n = 1'b1;
    #1;
    check_reset_state("reset");

    // 2. port 0 left rotate 0x96 by 2 -> 0x5A
    tick;
    req0_valid = 1'b1; req0_a = 8'h96; req0_amt = 3'd2; req0_lr = 1'b1;
    #1;
    check1("t2_rdy0", req0_ready, 1'b1);
    check1("t2_rdy1", req1_ready, 1'b0);
    tick;
    req0_valid = 1'b0;
    #1;
    check1("t2_rv0", resp0_valid, 1'b1);
    check1("t2_rv1", resp1_valid, 1'b0);
    check8("t2_y", resp_y, 8'h5A);
    check1("t2_grant", grant_id, 1'b0);
    check1("t2_busy", busy, 1'b1);
    resp0_ready = 1'b1;
    tick;
    resp0_ready = 1'b0;
    check1("t2_idle", busy, 1'b0);

    // 3. port 1 right rotate 0x96 by 2 -> 0xA5, response held 5 cycles
    req1_valid = 1'b1; req1_a = 8'h96; req1_amt = 3'd2; req1_lr = 1'b0;
    #1;
    check1("t3_rdy1", req1_ready, 1'b1);
    tick;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h11; req0_amt = 3'd1; req0_lr = 1'b1;
    resp0_ready = 1'b1;  // non-owner ready must be ignored
    for (int i = 0; i < 5; i++) begin
      #1;
      check8("t3_hold_y", resp_y, 8'hA5);
      check1("t3_hold_rv1", resp1_valid, 1'b1);
      check1("t3_hold_rv0", resp0_valid, 1'b0);
      check1("t3_hold_busy", busy, 1'b1);
      check1("t3_hold_rdy0", req0_ready, 1'b0);
      check1("t3_hold_grant", grant_id, 1'b1);
      tick;
    end
    resp0_ready = 1'b0;
    resp1_ready = 1'b1;
    tick;
    resp1_ready = 1'b0;
    #1;
    check1("t3_idle", busy, 1'b0);
    check1("t3_rdy0", req0_ready, 1'b1);
    tick;
    req0_valid = 1'b0;
    #1;
    check1("t3_rv0", resp0_valid, 1'b1);
    check8("t3_y0", resp_y, 8'h22);
    check1("t3_grant0", grant_id, 1'b0);
    resp0_ready = 1'b1;
    tick;
    resp0_ready = 1'b0;

    // Fresh reset so the arbitration history starts from its reset value.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick;

    // 4/5. contention: port 0 0x01, port 1 0x80, rotate left by 1
    req0_valid = 1'b1; req0_a = 8'h01; req0_amt = 3'd1; req0_lr = 1'b1;
    req1_valid = 1'b1; req1_a = 8'h80; req1_amt = 3'd1; req1_lr = 1'b1;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_ARB_RR_EN
      exp_w = i[0];
`else
      exp_w = 1'b0;
`endif
      exp_y = exp_w ? 8'h01 : 8'h02;
      #1;
      check1("t4_rdy0", req0_ready, ~exp_w);
      check1("t4_rdy1", req1_ready, exp_w);
      tick;
      check1("t4_rv0", resp0_valid, ~exp_w);
      check1("t4_rv1", resp1_valid, exp_w);
      check1("t4_grant", grant_id, exp_w);
      check8("t4_y", resp_y, exp_y);
      tick;
      check1("t4_idle", busy, 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    tick;

    // 6. reset while a response is pending
    req0_valid = 1'b1; req0_a = 8'hF0; req0_amt = 3'd3; req0_lr = 1'b0;
    tick;
    req0_valid = 1'b0;
    #1;
    check1("t6_rv0_pre", resp0_valid, 1'b1);
    check8("t6_y_pre", resp_y, 8'h1E);
    rst_n = 1'b0;
    #1;
    check_reset_state("t6_rst");
    tick;
    rst_n = 1'b1;
    req1_valid = 1'b1; req1_a = 8'h96; req1_amt = 3'd3; req1_lr = 1'b1;
    #1;
    check1("t6_rdy1", req1_ready, 1'b1);
    tick;
    req1_valid = 1'b0;
    #1;
    check1("t6_rv1", resp1_valid, 1'b1);
    check8("t6_y", resp_y, 8'hB4);
    check1("t6_grant", grant_id, 1'b1);
    resp1_ready = 1'b1;
    tick;
    resp1_ready = 1'b0;
    check1("t6_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_req_arbiter.md
# shift_req_arbiter

Two-requester arbiter and sequencer for the shared bidirectional rotating barrel shifter (`multi_barrel_shifter_mux`). Each requester issues rotate operations over a valid/ready handshake. The arbiter grants one operation at a time, drives the shifter, and registers the result. The result is held on a per-port response handshake until the owning requester consumes it. The block sits between the lab's stimulus/controller logic and the single shifter instance, so one datapath serves both sources.

## Interface
- `N`, default 8: data width; must be a power of 2 and ≥ 2.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: request present on port 0 / port 1.
- `req0_ready` / `req1_ready` out 1: request accepted this cycle when `valid & ready`.
- `req0_a` / `req1_a` in N: operand.
- `req0_amt` / `req1_amt` in $clog2(N): rotate amount.
- `req0_lr` / `req1_lr` in 1: direction; 1 = left, 0 = right.
- `resp0_valid` / `resp1_valid` out 1: result available for port 0 / port 1.
- `resp0_ready` / `resp1_ready` in 1: owning requester consumes the result.
- `resp_y` out N: registered result, shared by both ports; meaningful only while a `respX_valid` is high.
- `grant_id` out 1: port that owns the in-flight or most recent operation.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE and RESP.
- IDLE:
  - The arbiter picks one port among those with `reqX_valid=1`.
  - Only that port's `reqX_ready` goes high (combinational from state and valids). The other port's ready stays 0.
  - On accept: `a`, `amt` and `lr` from the winner are driven into the shifter. The shifter output is captured into `resp_y`, `grant_id` is set to the winner, and the FSM moves to RESP.
- RESP:
  - Both `reqX_ready` are 0.
  - `resp{grant_id}_valid` is 1 and the other port's `resp_valid` is 0.
  - `resp_y` and `grant_id` are stable.
  - When the owner's `resp_ready` is 1, the FSM moves to IDLE. The non-owner's `resp_ready` is ignored.
- Arbitration (round-robin build):
  - A 1-bit `last_grant` register is updated on every accept.
  - On contention, the port ≠ `last_grant` wins.
  - With a single requester, that requester wins regardless of `last_grant`.
- The shifter is purely combinational. Arithmetic is modulo rotation as the shifter defines it: amt=0 passes the operand through unchanged.
- Requesters must hold `a`, `amt`, `lr` and `valid` stable until ready. The block does not check this.

## Timing
- Reset values:
  - FSM = IDLE.
  - `resp_y` = 0.
  - `grant_id` = 0.
  - `last_grant` = 1, so port 0 wins first contention.
  - `resp0_valid` = `resp1_valid` = 0.
  - `busy` = 0.
  - Both readies follow IDLE rules immediately after reset deassertion.
- Latency: accept at edge T → `respX_valid` high in cycle T+1.
- Throughput: at most one operation per 2 cycles (accept, then response). A response consumed at edge T allows the next accept in the IDLE cycle that follows.
- Both valids arriving in the same cycle: exactly one ready is high. The loser is served no earlier than after the winner's response completes.
- A requester may hold its response indefinitely. The other requester is stalled; no timeout.
- A requester may raise a new `req_valid` while its own response is pending. It is not accepted until IDLE.
- Reset asserted mid-operation: the pending result is discarded and all outputs return to their reset values asynchronously.

## Configuration
- Macro `SHIFT_ARB_RR_EN`:
  - Defined: round-robin arbitration as described above.
  - Undefined: fixed priority, port 0 always wins contention. The `last_grant` register is not built; `grant_id` still reports the owner.

## Structure
- Shared package `shift_arb_pkg` holds:
  - the `typedef enum logic {IDLE, RESP}` state type;
  - the `PORTS = 2` constant.
- One sub-module: the existing `multi_barrel_shifter_mux #(.N(N))`, instantiated once.
- Arbitration and FSM live in this module.

## Test plan
1. Reset check: after reset with both valids low, all outputs hold their reset values and `req0_ready` = `req1_ready` = 0.
2. Single left rotate, N=8: port 0 issues a=0x96, amt=2, lr=1.
   - `req0_ready` is 1 in the accept cycle.
   - Next cycle: `resp0_valid`=1, `resp_y`=0x5A, `grant_id`=0, `resp1_valid`=0.
3. Single right rotate, N=8: port 1 issues a=0x96, amt=2, lr=0, with `resp1_ready` held low for 5 cycles.
   - `resp_y`=0xA5 stable throughout, `busy`=1, and a port 0 request is not accepted.
   - After `resp1_ready`=1: IDLE, then port 0 is accepted.
4. Contention, round-robin build: both ports request continuously (port 0 a=0x01, port 1 a=0x80, amt=1, lr=1) with responses always ready.
   - `grant_id` sequence is 0,1,0,1.
   - Results alternate 0x02, 0x01.
   - Accepts occur every 2 cycles.
5. Contention, fixed-priority build (`SHIFT_ARB_RR_EN` undefined): same stimulus gives `grant_id` always 0 and port 1 is never accepted.
6. Reset mid-operation: reset asserted in RESP with `resp0_valid`=1.
   - Outputs are immediately at reset values.
   - After release, a port 1 request is served with correct data.
